// File: rtl/chip_7458_tester_pkg.sv
// Shared types, widths and the reference AND-OR function for the 7458 tester.
// The tester and the optional golden wrapper both import this package.
package chip_7458_tester_pkg;

    localparam int VEC_W = 10;
    localparam int ERR_W = 11;
    localparam int CNT_W = 4;

    localparam logic [VEC_W-1:0] LAST_VEC = 10'd1023;
    localparam logic [ERR_W-1:0] ERR_MAX  = 11'd2047;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic p2y;
        logic p1y;
    } exp_t;

    // Bits 5:0 feed the two 3-input AND terms of p1y.
    // Bits 9:6 feed the two 2-input AND terms of p2y.
    function automatic exp_t expected_out(input logic [VEC_W-1:0] vec);
        exp_t r;
        r.p1y = (vec[0] & vec[1] & vec[2]) | (vec[3] & vec[4] & vec[5]);
        r.p2y = (vec[6] & vec[7]) | (vec[8] & vec[9]);
        return r;
    endfunction

endpackage

// File: rtl/chip_7458_golden.sv
// Combinational reference model of a good 7458.
// Wraps the package function so the tester compares against a named block.
module chip_7458_golden
    import chip_7458_tester_pkg::*;
(
    input  logic [VEC_W-1:0] vec_i,
    output exp_t             exp_o
);

    always_comb begin
        exp_o = expected_out(vec_i);
    end

endmodule

// File: rtl/chip_7458_tester.sv
// Exhaustive functional tester for a 7458 dual AND-OR gate.
// Steps all 1024 input vectors, waits SETTLE_CYCLES, then checks both outputs.
module chip_7458_tester
    import chip_7458_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [VEC_W-1:0] dut_in,
    input  logic             dut_p1y,
    input  logic             dut_p2y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] first_fail
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [VEC_W-1:0] ff_q, ff_d;
    logic             pass_q, pass_d;

    exp_t             exp_w;
    logic             mismatch;
    logic [ERR_W-1:0] err_nx;

    chip_7458_golden u_golden (
        .vec_i (idx_q),
        .exp_o (exp_w)
    );

    assign mismatch = (dut_p1y != exp_w.p1y) || (dut_p2y != exp_w.p2y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ff_d    = ff_q;
        pass_d  = pass_q;
        err_nx  = err_q;

        if (mismatch && (err_q != ERR_MAX)) begin
            err_nx = err_q + ERR_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                // start outranks a simultaneous abort here by construction.
                if (start) begin
                    state_d = SETTLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else begin
                    err_d = err_nx;
                    if (mismatch && (err_q == '0)) begin
                        ff_d = idx_q;
                    end
                    if (idx_q == LAST_VEC) begin
                        state_d = DONE;
                        pass_d  = (err_nx == '0);
                    end else begin
                        state_d = SETTLE;
                        idx_d   = idx_q + VEC_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs decode from registered state, so reset clears them at once.
    assign busy       = (state_q == SETTLE) || (state_q == CHECK);
    assign done       = (state_q == DONE);
    assign dut_in     = busy ? idx_q : '0;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule

// File: doc/chip_7458_tester.md
CHIP_7458_TESTER -- requirements
Module: chip_7458_tester

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, meaning: cycles inputs are held before outputs are sampled (legal range 1..15).
REQ-002 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port start  input  1  single-cycle request to begin a test run.
REQ-005 Port abort  input  1  terminate a run in progress.
REQ-006 Port dut_in  output  10  stimulus to the AND-OR device under test: bits 5:0 = p1a..p1f (bit0 = p1a), bits 9:6 = p2a..p2d (bit6 = p2a).
REQ-007 Port dut_p1y  input  1  device output p1y.
REQ-008 Port dut_p2y  input  1  device output p2y.
REQ-009 Port busy  output  1  run in progress.
REQ-010 Port done  output  1  one-cycle pulse at run completion.
REQ-011 Port pass  output  1  last completed run had zero mismatches.
REQ-012 Port err_count  output  11  mismatching vectors in current/last run.
REQ-013 Port first_fail  output  10  vector index of first mismatch; valid when err_count != 0.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, CHECK, DONE.
REQ-015 IDLE: start=1 -> SETTLE next cycle, with vector index = 0, err_count = 0, first_fail = 0, pass = 0, settle counter = 0.
REQ-016 dut_in SHALL equal the current vector index whenever busy = 1; it SHALL be 0 in IDLE and DONE.
REQ-017 SETTLE: hold dut_in for exactly SETTLE_CYCLES cycles, then CHECK.
REQ-018 Expected outputs: p1y = (b0&b1&b2)|(b3&b4&b5); p2y = (b6&b7)|(b8&b9).
REQ-019 CHECK (one cycle): compare dut_p1y/dut_p2y with expected for the current index; a mismatch on either output counts as one error.
REQ-020 On a mismatch, err_count SHALL increment, saturating at 2047; first_fail SHALL capture the index only when err_count was 0.
REQ-021 CHECK with index < 1023: increment index and go to SETTLE. CHECK with index = 1023: go to DONE.
REQ-022 Vectors SHALL be applied in ascending order 0..1023. Each vector takes SETTLE_CYCLES+1 cycles. The first done pulse SHALL occur 1024*(SETTLE_CYCLES+1)+1 cycles after the start cycle.
REQ-023 DONE (one cycle): done = 1; pass = (err_count == 0) including the final CHECK result; next state IDLE.
REQ-024 busy SHALL be 1 exactly in SETTLE and CHECK.
REQ-025 start while busy or in DONE SHALL be ignored.
REQ-026 abort in SETTLE or CHECK SHALL cause the following to occur on the next cycle: state IDLE, done not pulsed, pass = 0, err_count and first_fail held.
REQ-027 If abort and start are both high in IDLE, start wins.
REQ-028 pass, err_count and first_fail SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-029 rst = 1 SHALL asynchronously force state IDLE and set the index, settle counter, err_count, first_fail, pass, done, busy and dut_in to 0.
REQ-030 rst asserted mid-run SHALL discard the run; no done pulse SHALL follow.
REQ-031 The first start SHALL be accepted on the first clock edge after rst deasserts.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, VEC_W = 10, ERR_W = 11, LAST_VEC = 1023 and the expected-output function of REQ-018.
REQ-033 No sub-module is required; an optional combinational golden model, chip_7458_golden, MAY wrap the package function.

Verification (SETTLE_CYCLES = 2, bench instantiates a correct device unless stated)
REQ-034 Correct device, pulse start -> done 3073 cycles later, pass = 1, err_count = 0.
REQ-035 p1y stuck-at-0 -> err_count = 240, first_fail = 7, pass = 0.
REQ-036 p2y stuck-at-1 -> err_count = 576, first_fail = 0, pass = 0.
REQ-037 abort at cycle 100 -> busy = 0 one cycle later, no done pulse; a following start gives a full run with pass = 1.
REQ-038 start re-pulsed at cycle 50 of a run -> ignored, done still at cycle 3073.
REQ-039 rst pulsed mid-run -> all outputs 0 immediately, no done pulse; a subsequent start completes normally.
